// File: rtl/qed_pkg.sv
// Shared constants and types for the QED instruction buffer.
// Holds the NOP encoding, the record/replay state enum and the default depth.
package qed_pkg;

  localparam logic [31:0] QED_NOP   = 32'h0000_0013;
  localparam int          QED_DEPTH = 16;

  typedef enum logic {
    ORIG = 1'b0,
    DUP  = 1'b1
  } qed_state_t;

endpackage

// File: rtl/qed_ibuf_ram.sv
// Storage for one QED round of original instructions.
// It has one synchronous write port and one combinational read port. The storage is not reset.
module qed_ibuf_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [31:0]       o_rd_data
);

  logic [31:0] r_mem [DEPTH];

  // Capture an original instruction into its fetch-order slot.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/qed_instruction_buffer.sv
// Records the original instructions of a QED round and then replays them in fetch order as duplicates.
// It also exposes the original and duplicate counts that the consistency check compares.
module qed_instruction_buffer
  import qed_pkg::*;
#(
  parameter int DEPTH  = QED_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              exec_dup,
  input  logic              stall_IF,
  input  logic              instr_vld,
  input  logic [31:0]       ifu_qed_instruction,
  output logic [31:0]       qic_qimux_instruction,
  output logic              dup_active,
  output logic [ADDR_W:0]   num_orig_insts,
  output logic [ADDR_W:0]   num_dup_insts,
  output logic              buffer_full,
  output logic              qed_check_valid
);

  localparam int CNT_W = ADDR_W + 1;

  qed_state_t        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_num_orig;
  logic [CNT_W-1:0]  r_num_dup;
  logic [31:0]       r_instr;
  logic              r_dup_active;
  logic              r_check_valid;

  logic              w_active;
  logic              w_wr_en;
  logic [CNT_W-1:0]  w_orig_next;
  logic              w_go_dup;
  logic              w_dup_done;
  logic [31:0]       w_rd_data;

  assign w_active    = ena && !stall_IF;
  assign buffer_full = (r_num_orig == CNT_W'(DEPTH));
  assign w_wr_en     = w_active && (r_state == ORIG) && instr_vld && !buffer_full;
  assign w_orig_next = r_num_orig + {{ADDR_W{1'b0}}, w_wr_en};
  // The write in this cycle counts towards the round size, so exec_dup together with the first write is accepted.
  assign w_go_dup    = (w_orig_next == CNT_W'(DEPTH)) ||
                       (exec_dup && (w_orig_next != {CNT_W{1'b0}}));
  assign w_dup_done  = (r_num_dup == r_num_orig);

  qed_ibuf_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (ifu_qed_instruction),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Record/replay FSM together with the pointers, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ORIG;
      r_wr_ptr      <= {ADDR_W{1'b0}};
      r_rd_ptr      <= {ADDR_W{1'b0}};
      r_num_orig    <= {CNT_W{1'b0}};
      r_num_dup     <= {CNT_W{1'b0}};
      r_instr       <= QED_NOP;
      r_dup_active  <= 1'b0;
      r_check_valid <= 1'b0;
    end else if (stall_IF) begin
      r_state       <= r_state;
      r_wr_ptr      <= r_wr_ptr;
      r_rd_ptr      <= r_rd_ptr;
      r_num_orig    <= r_num_orig;
      r_num_dup     <= r_num_dup;
      r_instr       <= r_instr;
      r_dup_active  <= r_dup_active;
      r_check_valid <= r_check_valid;
    end else if (!ena) begin
      r_state       <= ORIG;
      r_wr_ptr      <= {ADDR_W{1'b0}};
      r_rd_ptr      <= {ADDR_W{1'b0}};
      r_num_orig    <= {CNT_W{1'b0}};
      r_num_dup     <= {CNT_W{1'b0}};
      r_instr       <= instr_vld ? ifu_qed_instruction : QED_NOP;
      r_dup_active  <= 1'b0;
      r_check_valid <= 1'b0;
    end else begin
      case (r_state)
        ORIG: begin
          r_dup_active  <= 1'b0;
          r_check_valid <= 1'b0;
          if (w_wr_en) begin
            r_instr    <= ifu_qed_instruction;
            r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
            r_num_orig <= w_orig_next;
          end else begin
            r_instr <= QED_NOP;
          end
          r_state <= w_go_dup ? DUP : ORIG;
        end
        DUP: begin
          // The cycle after the last duplicate has issued closes the round while both counts are still visible.
          if (w_dup_done) begin
            r_state       <= ORIG;
            r_wr_ptr      <= {ADDR_W{1'b0}};
            r_rd_ptr      <= {ADDR_W{1'b0}};
            r_num_orig    <= {CNT_W{1'b0}};
            r_num_dup     <= {CNT_W{1'b0}};
            r_instr       <= QED_NOP;
            r_dup_active  <= 1'b0;
            r_check_valid <= 1'b1;
          end else begin
            r_instr       <= w_rd_data;
            r_dup_active  <= 1'b1;
            r_rd_ptr      <= r_rd_ptr + ADDR_W'(1);
            r_num_dup     <= r_num_dup + CNT_W'(1);
            r_check_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= ORIG;
          r_wr_ptr      <= {ADDR_W{1'b0}};
          r_rd_ptr      <= {ADDR_W{1'b0}};
          r_num_orig    <= {CNT_W{1'b0}};
          r_num_dup     <= {CNT_W{1'b0}};
          r_instr       <= QED_NOP;
          r_dup_active  <= 1'b0;
          r_check_valid <= 1'b0;
        end
      endcase
    end
  end

  assign qic_qimux_instruction = r_instr;
  assign dup_active            = r_dup_active;
  assign num_orig_insts        = r_num_orig;
  assign num_dup_insts         = r_num_dup;
  // The pulse is held through a stall and stays masked until the stall releases.
  assign qed_check_valid       = r_check_valid && !stall_IF;

  // Keep w_active referenced so the enable qualifier stays available for debug probes.
  logic w_unused;
  assign w_unused = w_active;

endmodule

// File: tb/tb_qed_instruction_buffer.sv
// Self-checking bench for qed_instruction_buffer.
// It uses directed round scenarios plus a random soak, and checks against a queue-based reference model.
module tb_qed_instruction_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          DEP = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        exec_dup;
  logic        stall_IF;
  logic        instr_vld;
  logic [31:0] ifu_qed_instruction;
  logic [31:0] qic_qimux_instruction;
  logic        dup_active;
  logic [4:0]  num_orig_insts;
  logic [4:0]  num_dup_insts;
  logic        buffer_full;
  logic        qed_check_valid;

  qed_instruction_buffer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ena                   (ena),
    .exec_dup              (exec_dup),
    .stall_IF              (stall_IF),
    .instr_vld             (instr_vld),
    .ifu_qed_instruction   (ifu_qed_instruction),
    .qic_qimux_instruction (qic_qimux_instruction),
    .dup_active            (dup_active),
    .num_orig_insts        (num_orig_insts),
    .num_dup_insts         (num_dup_insts),
    .buffer_full           (buffer_full),
    .qed_check_valid       (qed_check_valid)
  );

  always #5 clk = ~clk;

  // Reference model: the recorded round as a queue, the number replayed so far, and the visible outputs.
  logic [31:0] m_q[$];
  int          m_ri;
  bit          m_dup;
  logic [31:0] m_out;
  bit          m_dupa;
  bit          m_pulse;

  int n_pass  = 0;
  int n_total = 0;
  int n_step  = 0;

  task automatic model_reset();
    m_q.delete();
    m_ri = 0; m_dup = 0; m_out = NOP; m_dupa = 0; m_pulse = 0;
  endtask

  task automatic model_edge(input bit e, input bit x, input bit s, input bit v, input logic [31:0] ins);
    if (s) return;
    if (!e) begin
      model_reset();
      m_out = v ? ins : NOP;
    end else if (!m_dup) begin
      m_pulse = 0; m_dupa = 0;
      if (v && m_q.size() < DEP) begin
        m_q.push_back(ins);
        m_out = ins;
      end else begin
        m_out = NOP;
      end
      if (m_q.size() == DEP || (x && m_q.size() >= 1)) m_dup = 1;
    end else if (m_ri < m_q.size()) begin
      m_out = m_q[m_ri];
      m_ri++;
      m_dupa = 1; m_pulse = 0;
    end else begin
      model_reset();
      m_pulse = 1;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL step%0d %s: got %h expected %h", n_step, name, obs, exp);
  endtask

  task automatic check_all();
    cmp("instr",       qic_qimux_instruction, m_out);
    cmp("dup_active",  {31'd0, dup_active}, {31'd0, m_dupa});
    cmp("num_orig",    {27'd0, num_orig_insts}, 32'(m_q.size()));
    cmp("num_dup",     {27'd0, num_dup_insts}, 32'(m_ri));
    cmp("buffer_full", {31'd0, buffer_full}, {31'd0, (m_q.size() == DEP)});
    cmp("check_valid", {31'd0, qed_check_valid}, {31'd0, (m_pulse && !stall_IF)});
  endtask

  task automatic step(input bit e, input bit x, input bit s, input bit v, input logic [31:0] ins);
    ena = e; exec_dup = x; stall_IF = s; instr_vld = v; ifu_qed_instruction = ins;
    #1;
    check_all();
    @(posedge clk);
    model_edge(e, x, s, v, ins);
    @(negedge clk);
    n_step++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; exec_dup = 1'b0; stall_IF = 1'b0; instr_vld = 1'b0;
    ifu_qed_instruction = 32'd0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic round of three instructions with exec_dup alongside the last one.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0020_8133);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h00a0_2023);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_a083);
    idle(5);

    // Full buffer: sixteen originals, then input offered throughout the automatic replay.
    for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    for (int i = 0; i < DEP + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    idle(2);

    // exec_dup with nothing recorded, then exec_dup together with the second write.
    step(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b1, $urandom);
    idle(4);

    // Stall for three cycles in the middle of a replay.
    for (int i = 0; i < 5; i++) step(1'b1, (i == 4), 1'b0, 1'b1, $urandom);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, $urandom);
    idle(6);

    // Stall right on the completion pulse.
    step(1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b1, $urandom);
    idle(3);
    step(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
    step(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
    idle(2);

    // Gaps in ORIG, then ena dropped mid-round.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), $urandom);
    step(1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b1, $urandom);
    idle(4);

    // Asynchronous reset in the middle of a replay.
    for (int i = 0; i < 4; i++) step(1'b1, (i == 3), 1'b0, 1'b1, $urandom);
    idle(2);
    ena = 1'b1; stall_IF = 1'b0; exec_dup = 1'b0; instr_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_step++;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'hdead_beef);
    idle(3);

    // Random soak.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 6) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7), $urandom);
    end
    idle(DEP + 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
